clk_div_ctrl: RTL and testbench

//  Runtime ratio controller for the PUSCH divided clock. Two requesters (e.g. config bus and

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_prog.sv | 48 ++++
 rtl/clk_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-retunable clock divider.
package clk_div_pkg;

   localparam int unsigned DIV_W_DEF = 8;
   localparam int unsigned MIN_DIV   = 2;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StWaitBnd,
      StGate,
      StLoad
   } state_e;

endpackage

// File: rtl/clk_div_prog.sv
// Programmable divider: cnt runs 1..ratio, clk_out high for the first ceil(ratio/2) counts.
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] ratio,
   input  logic             hold,
   input  logic             restart,
   output logic             bnd,
   output logic             clk_out
);

   logic [DIV_W-1:0] cnt_q, cnt_d, half;
   logic             clk_out_q, clk_out_d;

   always_comb begin
      // ceil(ratio/2) without needing a wider adder
      half      = (ratio >> 1) + {{(DIV_W-1){1'b0}}, ratio[0]};
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      if (restart) begin
         cnt_d     = DIV_W'(1);
         clk_out_d = 1'b1;
      end else if (hold) begin
         clk_out_d = 1'b0;
      end else begin
         cnt_d     = (cnt_q == '0 || cnt_q >= ratio) ? DIV_W'(1) : cnt_q + DIV_W'(1);
         clk_out_d = (cnt_d <= half);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
      end
   end

   assign bnd     = (cnt_q == ratio);
   assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Ratio controller: round-robin arbitration of two ratio requests and glitch-free retuning
// of the divided clock at a period boundary.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W    = DIV_W_DEF,
   parameter int unsigned DEF_DIV  = 16,
   parameter int unsigned GATE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [DIV_W-1:0] ratio0,
   input  logic [DIV_W-1:0] ratio1,
   output logic [1:0]       ack,
   output logic             err,
   output logic             busy,
   output logic [DIV_W-1:0] cur_div,
   output logic             clk_out
);

   if (DEF_DIV < MIN_DIV) begin : g_bad_def_div
      $error("clk_div_ctrl: DEF_DIV must be >= 2");
   end
   if (GATE_CYC > 15) begin : g_bad_gate_cyc
      $error("clk_div_ctrl: GATE_CYC must be in 0..15");
   end

   localparam logic [DIV_W-1:0] DefDiv   = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] MinDiv   = DIV_W'(MIN_DIV);
   localparam logic [3:0]       GateLast = 4'(GATE_CYC - 1);

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d, gnt_q, gnt_d;
   logic [DIV_W-1:0] lat_q, lat_d, cur_div_q, cur_div_d;
   logic [1:0]       ack_q, ack_d;
   logic             err_q, err_d;
   logic [3:0]       gcnt_q, gcnt_d;
   logic             hold, restart, bnd, load_now;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      lat_d     = lat_q;
      cur_div_d = cur_div_q;
      ack_d     = 2'b00;
      err_d     = 1'b0;
      gcnt_d    = gcnt_q;
      hold      = 1'b0;
      restart   = 1'b0;
      load_now  = 1'b0;
      case (state_q)
         StIdle: begin
            // ack_q high means the requester has not yet had a chance to drop req
            if ((|req) && !(|ack_q)) begin
               gnt_d   = (req == 2'b11) ? ptr_q : req[1];
               ptr_d   = ~gnt_d;
               lat_d   = gnt_d ? ratio1 : ratio0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (lat_q < MinDiv || lat_q == cur_div_q) begin
               ack_d[gnt_q] = 1'b1;
               err_d        = (lat_q < MinDiv);
               state_d      = StIdle;
            end else begin
               state_d = StWaitBnd;
            end
         end
         StWaitBnd: begin
            // The boundary cycle is already low, so it serves as the first gated cycle
            if (bnd) begin
               if (GATE_CYC == 0) begin
                  load_now = 1'b1;
               end else begin
                  hold    = 1'b1;
                  gcnt_d  = 4'd1;
                  state_d = (GATE_CYC == 1) ? StLoad : StGate;
               end
            end
         end
         StGate: begin
            hold   = 1'b1;
            gcnt_d = gcnt_q + 4'd1;
            if (gcnt_q == GateLast) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            load_now = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (load_now) begin
         restart   = 1'b1;
         cur_div_d = lat_q;
         state_d   = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= 1'b0;
         gnt_q     <= 1'b0;
         lat_q     <= '0;
         cur_div_q <= DefDiv;
         ack_q     <= 2'b00;
         err_q     <= 1'b0;
         gcnt_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         lat_q     <= lat_d;
         cur_div_q <= cur_div_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         gcnt_q    <= gcnt_d;
      end
   end

   clk_div_prog #(
      .DIV_W(DIV_W)
   ) u_prog (
      .clk    (clk),
      .rst_n  (rst_n),
      .ratio  (cur_div_q),
      .hold   (hold),
      .restart(restart),
      .bnd    (bnd),
      .clk_out(clk_out)
   );

   assign ack     = ack_q | ({gnt_q, ~gnt_q} & {2{load_now}});
   assign err     = err_q;
   assign busy    = (state_q != StIdle) | (|ack_q);
   assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl against a period/boundary arithmetic model.
module tb_clk_div_ctrl;

   localparam int DW  = 8;
   localparam int DEF = 16;
   localparam int G   = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req = 2'b00;
   logic [DW-1:0] ratio0 = '0;
   logic [DW-1:0] ratio1 = '0;
   logic [1:0]    ack;
   logic          err, busy, clk_out;
   logic [DW-1:0] cur_div;

   clk_div_ctrl #(
      .DIV_W   (DW),
      .DEF_DIV (DEF),
      .GATE_CYC(G)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .ratio0 (ratio0),
      .ratio1 (ratio1),
      .ack    (ack),
      .err    (err),
      .busy   (busy),
      .cur_div(cur_div),
      .clk_out(clk_out)
   );

   always #5 clk = ~clk;

   // Cycle index: cycle 1 is the first one after reset release
   int cyc = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   logic [12:0] obs;
   assign obs = {clk_out, cur_div, ack, err, busy};

   int n_chk = 0;
   int n_err = 0;
   logic [12:0] ev;

   // Model: current ratio/period start plus one in-flight transaction plan
   int       m_div = DEF, m_start = 1, ptr = 0;
   logic [1:0] pend = 2'b00;
   bit       t_valid = 0, t_sw = 0, t_err = 0;
   int       t_c, t_ack, t_b, t_new, t_side;

   function automatic bit clkf(int k, int st, int n);
      return (k >= st) && (((k - st) % n) < (n + 1) / 2);
   endfunction

   function automatic logic [12:0] exp_vec(int k);
      logic c, e, b;
      logic [DW-1:0] d;
      logic [1:0] a;
      c = clkf(k, m_start, m_div);
      d = DW'(m_div);
      a = 2'b00; e = 1'b0; b = 1'b0;
      if (t_valid) begin
         if (k > t_c && k <= t_ack) b = 1'b1;
         if (k == t_ack) begin a[t_side] = 1'b1; e = t_err; end
         if (t_sw && k > t_b && k <= t_ack) c = 1'b0;
      end
      return {c, d, a, e, b};
   endfunction

   // Plan the next grant; c is the IDLE cycle in which the DUT sees the request
   task automatic plan_next(int c);
      int r;
      if (pend == 2'b00) begin t_valid = 0; return; end
      t_side = (pend == 2'b11) ? ptr : (pend[1] ? 1 : 0);
      ptr    = 1 - t_side;
      r      = t_side ? int'(ratio1) : int'(ratio0);
      t_valid = 1; t_c = c; t_sw = 0; t_err = 0;
      if (r < 2) begin
         t_ack = c + 2; t_err = 1;
      end else if (r == m_div) begin
         t_ack = c + 2;
      end else begin
         t_sw = 1; t_new = r; t_b = c + 2;
         while (((t_b - m_start) % m_div) != m_div - 1) t_b++;
         t_ack = t_b + G;
      end
   endtask

   task automatic issue(logic [1:0] bits, int r0, int r1);
      ratio0 = DW'(r0); ratio1 = DW'(r1);
      req = bits; pend = bits;
      plan_next(cyc);
   endtask

   // Requester drops req in its ack cycle; a still-held request is seen next cycle
   task automatic advance(int k);
      if (t_valid && k == t_ack) begin
         req[t_side]  = 1'b0;
         pend[t_side] = 1'b0;
         if (t_sw) begin m_div = t_new; m_start = t_ack + 1; end
         t_valid = 0;
         plan_next(k + 1);
      end
   endtask

   task automatic model_reset();
      m_div = DEF; m_start = 1; ptr = 0; pend = 2'b00; t_valid = 0; req = 2'b00;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL reset cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL free_run cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
   endtask

   task automatic test_switch();
      for (int i = 0; i < 40 && ((cyc - m_start) % m_div) != 3; i++) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL align cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
      issue(2'b01, 5, 0);
      for (int i = 0; i < 400 && t_valid; i++) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL switch cyc=%0d got=%b want=%b", cyc, obs, ev); end
         advance(cyc);
      end
      if (t_valid) begin n_chk++; n_err++; $display("FAIL switch timeout got=busy want=idle"); end
      repeat (20) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL after_switch cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
   endtask

   task automatic test_reject();
      for (int r = 1; r >= 0; r--) begin
         issue(2'b10, 0, r);
         for (int i = 0; i < 400 && t_valid; i++) begin
            @(negedge clk); ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) begin n_err++; $display("FAIL reject r=%0d cyc=%0d got=%b want=%b", r, cyc, obs, ev); end
            advance(cyc);
         end
         repeat (6) begin
            @(negedge clk); ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) begin n_err++; $display("FAIL after_reject cyc=%0d got=%b want=%b", cyc, obs, ev); end
         end
      end
   endtask

   task automatic test_round_robin();
      for (int p = 0; p < 2; p++) begin
         if (p == 0) issue(2'b11, 4, 6);
         else        issue(2'b11, 9, 3);
         for (int i = 0; i < 400 && t_valid; i++) begin
            @(negedge clk); ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) begin n_err++; $display("FAIL rr pair=%0d cyc=%0d got=%b want=%b", p, cyc, obs, ev); end
            advance(cyc);
         end
         if (t_valid) begin n_chk++; n_err++; $display("FAIL rr timeout got=busy want=idle"); end
         repeat (12) begin
            @(negedge clk); ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) begin n_err++; $display("FAIL after_rr cyc=%0d got=%b want=%b", cyc, obs, ev); end
         end
      end
   endtask

   task automatic test_noop();
      issue(2'b01, m_div, 0);
      for (int i = 0; i < 400 && t_valid; i++) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL noop cyc=%0d got=%b want=%b", cyc, obs, ev); end
         advance(cyc);
      end
      repeat (10) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL after_noop cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
   endtask

   task automatic test_reset_mid();
      issue(2'b01, (m_div == 7) ? 9 : 7, 0);
      for (int i = 0; i < 400 && cyc != t_b + 1; i++) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL pre_gate cyc=%0d got=%b want=%b", cyc, obs, ev); end
         advance(cyc);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      ev = exp_vec(cyc); n_chk++;
      if (obs !== ev) begin n_err++; $display("FAIL reset_in_gate got=%b want=%b", obs, ev); end
      repeat (2) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL held_reset cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk); ev = exp_vec(cyc); n_chk++;
         if (obs !== ev) begin n_err++; $display("FAIL after_reset cyc=%0d got=%b want=%b", cyc, obs, ev); end
      end
   endtask

   task automatic test_random();
      int r[2];
      logic [1:0] bits;
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(1, 5)) begin
            @(negedge clk); ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) begin n_err++; $display("FAIL rnd_gap cyc=%0d got=%b want=%b", cyc, obs, ev); end
         end
         bits = 2'($urandom_range(1, 3));
         for (int s = 0; s < 2; s++) begin
            case ($urandom_range(0, 3))
               0:       r[s] = $urandom_range(0, 1);
               1:       r[s] = m_div;
               default: r[s] = $urandom_range(2, 24);
            endcase
         end
         issue(bits, r[0], r[1]);
         for (int i = 0; i < 400 && t_valid; i++) begin
            @(negedge clk); ev = exp_vec(cyc); n_chk++;
            if (obs !== ev) begin n_err++; $display("FAIL rnd n=%0d cyc=%0d got=%b want=%b", n, cyc, obs, ev); end
            advance(cyc);
         end
         if (t_valid) begin n_chk++; n_err++; $display("FAIL rnd timeout got=busy want=idle"); end
      end
   endtask

   initial begin
      test_reset();
      test_switch();
      test_reject();
      test_round_robin();
      test_noop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
